mcdf_formatter: RTL and testbench
=================================

MCDF_FORMATTER -- requirements
Module: mcdf_formatter

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 32, meaning store-and-forward buffer depth in 32-bit words; it SHALL be at least the maximum package length.
REQ-002 SHALL have port clk_i, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port a2f_val_i, input, 1 bit: arbiter word valid.
REQ-005 SHALL have port a2f_id_i, input, 2 bits: channel id of the granted slave.
REQ-006 SHALL have port a2f_data_i, input, 32 bits: arbiter data word.
REQ-007 SHALL have port a2f_pkglen_sel_i, input, 3 bits: package-length code of the granted channel.
REQ-008 SHALL have port f2a_id_req_o, output, 1 bit: request to the arbiter for the next channel grant.
REQ-009 SHALL have port f2a_ack_o, output, 1 bit: word-accepted acknowledge to the arbiter.
REQ-010 SHALL have port fmt_grant_i, input, 1 bit: downstream grant.
REQ-011 SHALL have port fmt_req_o, output, 1 bit: packet-ready request to downstream.
REQ-012 SHALL have port fmt_chid_o, output, 2 bits: channel id of the packet.
REQ-013 SHALL have port fmt_length_o, output, 6 bits: packet length in words.
REQ-014 SHALL have port fmt_data_o, output, 32 bits: packet word.
REQ-015 SHALL have port fmt_start_o, output, 1 bit: first-word marker.
REQ-016 SHALL have port fmt_end_o, output, 1 bit: last-word marker.

Function
REQ-017 SHALL decode the length from a2f_pkglen_sel_i as 0->4, 1->8, 2->16, 3->32, and 4..7->32.
REQ-018 SHALL implement the FSM states IDLE, ID_REQ, COLLECT, REQ and SEND, one-hot or encoded.
REQ-019 IDLE SHALL transition unconditionally to ID_REQ on the next edge, giving one idle cycle between packets.
REQ-020 In ID_REQ, f2a_id_req_o SHALL be 1 (registered); otherwise f2a_id_req_o SHALL be 0.
REQ-021 f2a_ack_o SHALL be combinational: 1 iff the state is ID_REQ or COLLECT, a2f_val_i=1, and the word count is less than the latched length.
REQ-022 A word SHALL be accepted only when a2f_val_i=1 and f2a_ack_o=1 in the same cycle; each accepted word SHALL be written into the buffer in arrival order.
REQ-023 On the first accepted word in ID_REQ, the block SHALL latch a2f_id_i and the decoded length, set the count to 1, and go to COLLECT; if the length is 1 it SHALL go to REQ.
REQ-024 COLLECT SHALL increment the count per accepted word and SHALL tolerate a2f_val_i bubbles of any length; when the count reaches the latched length it SHALL go to REQ.
REQ-025 a2f_id_i and a2f_pkglen_sel_i SHALL be ignored after the first word of a packet.
REQ-026 a2f_val_i outside ID_REQ and COLLECT SHALL be ignored with f2a_ack_o=0; the buffer SHALL never overflow.
REQ-027 In REQ, fmt_req_o SHALL be 1, and fmt_chid_o and fmt_length_o SHALL hold the latched values; the block SHALL wait indefinitely for fmt_grant_i.
REQ-028 When fmt_grant_i=1 is sampled in REQ, fmt_req_o SHALL drop at that edge and the state SHALL become SEND.
REQ-029 In SEND, the block SHALL drive one word per cycle on fmt_data_o (registered), starting in the cycle after the grant.
REQ-030 In SEND, fmt_start_o SHALL be 1 on the first word only, and fmt_end_o SHALL be 1 on the last word only; both SHALL be 1 on the same word if the length is 1.
REQ-031 After the last word, the state SHALL return to IDLE; fmt_data_o, fmt_start_o and fmt_end_o SHALL be 0 outside SEND words.
REQ-032 fmt_grant_i outside REQ SHALL be ignored.
REQ-033 Buffer read and write pointers SHALL wrap modulo BUF_DEPTH, and both SHALL be cleared at the start of each packet.
REQ-034 fmt_chid_o and fmt_length_o SHALL remain stable from REQ entry until the end of SEND.

Reset
REQ-035 On rstn_i=0, the block SHALL, asynchronously, set the state to IDLE, clear the pointers and count, and drive all outputs to 0.
REQ-036 Reset mid-packet (in any state) SHALL discard the partial packet; the first packet after release SHALL begin with a fresh ID_REQ.
REQ-037 After rstn_i rises, f2a_id_req_o SHALL first assert on the second rising edge.

Verification
REQ-038 sel=0, id=2, four back-to-back words A0..A3, grant immediate -> fmt_req_o=1 with chid=2 and length=4, then A0..A3 with start on A0 and end on A3, one idle cycle, then f2a_id_req_o=1.
REQ-039 sel=3, 32 words with random val bubbles -> exactly 32 acks, no ack beyond the 32nd word, and output words in order.
REQ-040 Packet collected, grant delayed 10 cycles -> fmt_req_o held 10 cycles, chid and length stable, no acks during the wait.
REQ-041 sel=5 -> length 32 decoded.
REQ-042 rstn_i pulsed low after 3 of 8 words -> all outputs 0 immediately, and the next packet starts clean with count 0.
REQ-043 a2f_val_i=1 in REQ/SEND and fmt_grant_i=1 in COLLECT -> f2a_ack_o=0, and no state change caused by either input.

Source files
------------

// File: rtl/mcdf_formatter.sv
// MCDF formatter: collects one package from the arbiter into a store-and-forward
// buffer, then requests the downstream link and streams it out word by word.
module mcdf_formatter #(
   parameter int BUF_DEPTH = 32
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        a2f_val_i,
   input  logic [1:0]  a2f_id_i,
   input  logic [31:0] a2f_data_i,
   input  logic [2:0]  a2f_pkglen_sel_i,
   output logic        f2a_id_req_o,
   output logic        f2a_ack_o,
   input  logic        fmt_grant_i,
   output logic        fmt_req_o,
   output logic [1:0]  fmt_chid_o,
   output logic [5:0]  fmt_length_o,
   output logic [31:0] fmt_data_o,
   output logic        fmt_start_o,
   output logic        fmt_end_o
);
   localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ID_REQ, S_COLLECT, S_REQ, S_SEND} state_t;

   state_t         r_state;
   logic           r_armed;
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [5:0]     r_cnt;
   logic [5:0]     r_sent;
   logic [5:0]     r_len;
   logic [1:0]     r_chid;
   logic [31:0]    r_mem [BUF_DEPTH];

   logic [5:0]     w_dec_len;
   logic [5:0]     w_len_lim;
   logic           w_ack;

   function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
      return (p == AW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      w_dec_len = 6'd32;
      case (a2f_pkglen_sel_i)
         3'd0:    w_dec_len = 6'd4;
         3'd1:    w_dec_len = 6'd8;
         3'd2:    w_dec_len = 6'd16;
         default: w_dec_len = 6'd32;
      endcase
   end

   // Before the first word nothing is latched yet, so compare against the live code.
   assign w_len_lim = (r_state == S_ID_REQ) ? w_dec_len : r_len;
   assign w_ack     = ((r_state == S_ID_REQ) || (r_state == S_COLLECT)) &&
                      a2f_val_i && (r_cnt < w_len_lim);

   assign f2a_ack_o    = w_ack;
   assign fmt_chid_o   = r_chid;
   assign fmt_length_o = r_len;

   always_ff @(posedge clk_i) begin
      if (w_ack)
         r_mem[r_wr_ptr] <= a2f_data_i;
   end

   // r_armed holds IDLE for one extra cycle after reset release only.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state      <= S_IDLE;
         r_armed      <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_cnt        <= '0;
         r_sent       <= '0;
         r_len        <= '0;
         r_chid       <= '0;
         f2a_id_req_o <= 1'b0;
         fmt_req_o    <= 1'b0;
         fmt_data_o   <= '0;
         fmt_start_o  <= 1'b0;
         fmt_end_o    <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_wr_ptr    <= '0;
               r_rd_ptr    <= '0;
               r_cnt       <= '0;
               r_sent      <= '0;
               fmt_data_o  <= '0;
               fmt_start_o <= 1'b0;
               fmt_end_o   <= 1'b0;
               if (r_armed) begin
                  r_state      <= S_ID_REQ;
                  f2a_id_req_o <= 1'b1;
               end
            end
            S_ID_REQ: begin
               if (w_ack) begin
                  r_wr_ptr     <= f_next(r_wr_ptr);
                  r_chid       <= a2f_id_i;
                  r_len        <= w_dec_len;
                  r_cnt        <= 6'd1;
                  f2a_id_req_o <= 1'b0;
                  if (w_dec_len == 6'd1) begin
                     r_state   <= S_REQ;
                     fmt_req_o <= 1'b1;
                  end else begin
                     r_state   <= S_COLLECT;
                  end
               end
            end
            S_COLLECT: begin
               if (w_ack) begin
                  r_wr_ptr <= f_next(r_wr_ptr);
                  r_cnt    <= r_cnt + 6'd1;
                  if (r_cnt + 6'd1 == r_len) begin
                     r_state   <= S_REQ;
                     fmt_req_o <= 1'b1;
                  end
               end
            end
            S_REQ: begin
               // First word goes out on the grant edge itself.
               if (fmt_grant_i) begin
                  fmt_req_o   <= 1'b0;
                  r_state     <= S_SEND;
                  fmt_data_o  <= r_mem[r_rd_ptr];
                  fmt_start_o <= 1'b1;
                  fmt_end_o   <= (r_len == 6'd1);
                  r_rd_ptr    <= f_next(r_rd_ptr);
                  r_sent      <= 6'd1;
               end
            end
            S_SEND: begin
               if (r_sent < r_len) begin
                  fmt_data_o  <= r_mem[r_rd_ptr];
                  fmt_start_o <= 1'b0;
                  fmt_end_o   <= (r_sent == r_len - 6'd1);
                  r_rd_ptr    <= f_next(r_rd_ptr);
                  r_sent      <= r_sent + 6'd1;
               end else begin
                  fmt_data_o  <= '0;
                  fmt_start_o <= 1'b0;
                  fmt_end_o   <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mcdf_formatter.sv
// Directed bench for mcdf_formatter: packages of several lengths, bubbles,
// delayed grant, ignored stray inputs and a mid-packet reset.
module tb_mcdf_formatter;
   logic        clk_i;
   logic        rstn_i;
   logic        a2f_val_i;
   logic [1:0]  a2f_id_i;
   logic [31:0] a2f_data_i;
   logic [2:0]  a2f_pkglen_sel_i;
   logic        f2a_id_req_o;
   logic        f2a_ack_o;
   logic        fmt_grant_i;
   logic        fmt_req_o;
   logic [1:0]  fmt_chid_o;
   logic [5:0]  fmt_length_o;
   logic [31:0] fmt_data_o;
   logic        fmt_start_o;
   logic        fmt_end_o;

   int          n_total;
   int          n_bad;
   logic [31:0] exp_q[$];

   mcdf_formatter #(.BUF_DEPTH(32)) dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .a2f_val_i        (a2f_val_i),
      .a2f_id_i         (a2f_id_i),
      .a2f_data_i       (a2f_data_i),
      .a2f_pkglen_sel_i (a2f_pkglen_sel_i),
      .f2a_id_req_o     (f2a_id_req_o),
      .f2a_ack_o        (f2a_ack_o),
      .fmt_grant_i      (fmt_grant_i),
      .fmt_req_o        (fmt_req_o),
      .fmt_chid_o       (fmt_chid_o),
      .fmt_length_o     (fmt_length_o),
      .fmt_data_o       (fmt_data_o),
      .fmt_start_o      (fmt_start_o),
      .fmt_end_o        (fmt_end_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_id_req"}, f2a_id_req_o, 0);
      chk({tag, "_ack"},    f2a_ack_o,    0);
      chk({tag, "_req"},    fmt_req_o,    0);
      chk({tag, "_chid"},   fmt_chid_o,   0);
      chk({tag, "_len"},    fmt_length_o, 0);
      chk({tag, "_data"},   fmt_data_o,   0);
      chk({tag, "_start"},  fmt_start_o,  0);
      chk({tag, "_end"},    fmt_end_o,    0);
   endtask

   // Drive words until n are acknowledged; id/sel are scrambled after the first word.
   task automatic feed(input logic [1:0] id, input logic [2:0] sel, input int n,
                       input bit bub, input bit gnoise, input bit full, input logic [31:0] base);
      int acks;
      int cyc;
      acks = 0;
      cyc  = 0;
      fmt_grant_i = gnoise;
      while (acks < n && cyc < 400) begin
         a2f_val_i        = bub ? ($urandom_range(0, 2) != 0) : 1'b1;
         a2f_data_i       = base + 32'(acks);
         a2f_id_i         = (acks == 0) ? id : ~id;
         a2f_pkglen_sel_i = (acks == 0) ? sel : ((sel == 3'd0) ? 3'd3 : 3'd0);
         #1;
         if (a2f_val_i && f2a_ack_o) begin
            exp_q.push_back(a2f_data_i);
            acks++;
         end
         tick();
         cyc++;
      end
      fmt_grant_i = 1'b0;
      chk("acks", acks, n);
      if (full) begin
         a2f_val_i  = 1'b1;
         a2f_data_i = 32'hBAD0_0000;
         #1;
         chk("ack_after_last", f2a_ack_o, 0);
      end
   endtask

   task automatic drain(input logic [1:0] chid, input logic [5:0] len, input int delay);
      logic [31:0] e;
      a2f_val_i  = 1'b1;
      a2f_data_i = 32'hBAD1_0000;
      #1;
      chk("req_on", fmt_req_o, 1);
      chk("chid", fmt_chid_o, chid);
      chk("len", fmt_length_o, len);
      chk("id_req_off", f2a_id_req_o, 0);
      for (int i = 0; i < delay; i++) begin
         tick();
         chk("req_hold", fmt_req_o, 1);
         chk("ack_in_req", f2a_ack_o, 0);
         chk("chid_hold", fmt_chid_o, chid);
         chk("len_hold", fmt_length_o, len);
         chk("start_in_req", fmt_start_o, 0);
      end
      fmt_grant_i = 1'b1;
      for (int k = 0; k < len; k++) begin
         tick();
         fmt_grant_i = (k % 3 == 1);
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else                  e = 32'hDEAD_BEEF;
         chk("data", fmt_data_o, e);
         chk("start", fmt_start_o, k == 0);
         chk("end", fmt_end_o, k == len - 1);
         chk("req_off", fmt_req_o, 0);
         chk("ack_in_send", f2a_ack_o, 0);
         chk("chid_send", fmt_chid_o, chid);
         chk("len_send", fmt_length_o, len);
      end
      fmt_grant_i = 1'b0;
      a2f_val_i   = 1'b0;
      tick();
      chk("data_idle", fmt_data_o, 0);
      chk("start_idle", fmt_start_o, 0);
      chk("end_idle", fmt_end_o, 0);
      chk("id_req_idle", f2a_id_req_o, 0);
      tick();
      chk("id_req_next", f2a_id_req_o, 1);
      $display("packet chid=%0d len=%0d grant_delay=%0d checked", chid, len, delay);
   endtask

   initial begin
      n_total          = 0;
      n_bad            = 0;
      rstn_i           = 1'b0;
      a2f_val_i        = 1'b1;
      a2f_id_i         = 2'd0;
      a2f_data_i       = 32'h0;
      a2f_pkglen_sel_i = 3'd0;
      fmt_grant_i      = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk_all_zero("rst");
      a2f_val_i   = 1'b0;
      fmt_grant_i = 1'b0;
      rstn_i      = 1'b1;
      tick();
      chk("rel_edge1_id_req", f2a_id_req_o, 0);
      tick();
      chk("rel_edge2_id_req", f2a_id_req_o, 1);

      // len 4, back-to-back, grant held high while collecting
      feed(2'd2, 3'd0, 4, 1'b0, 1'b1, 1'b1, 32'h0000_00A0);
      drain(2'd2, 6'd4, 0);
      // len 32 with bubbles
      feed(2'd1, 3'd3, 32, 1'b1, 1'b0, 1'b1, 32'h1000_0000);
      drain(2'd1, 6'd32, 0);
      // len 16, grant delayed 10 cycles
      feed(2'd3, 3'd2, 16, 1'b0, 1'b1, 1'b1, 32'h2000_0000);
      drain(2'd3, 6'd16, 10);
      // out-of-range code decodes to 32
      feed(2'd0, 3'd5, 32, 1'b1, 1'b0, 1'b1, 32'h3000_0000);
      drain(2'd0, 6'd32, 0);

      // reset after 3 of 8 words
      feed(2'd2, 3'd1, 3, 1'b0, 1'b0, 1'b0, 32'h4000_0000);
      a2f_val_i = 1'b1;
      #2;
      rstn_i = 1'b0;
      #1;
      chk_all_zero("midrst");
      exp_q.delete();
      a2f_val_i = 1'b0;
      @(negedge clk_i);
      rstn_i = 1'b1;
      tick();
      chk("rel2_edge1_id_req", f2a_id_req_o, 0);
      tick();
      chk("rel2_edge2_id_req", f2a_id_req_o, 1);
      feed(2'd2, 3'd1, 8, 1'b0, 1'b0, 1'b1, 32'h5000_0000);
      drain(2'd2, 6'd8, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
   end
endmodule
